// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and helpers for the FIFO write-port arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Grant index width; clamped to one bit so a degenerate count still elaborates.
  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int c_DEFAULT_NUM_REQ = 4;
  localparam int c_DEFAULT_IDX_W   = arb_idx_w(c_DEFAULT_NUM_REQ);

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker (double-width masked priority enc)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_pick,
  output logic               o_any_req
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_win;
  logic [2*NUM_REQ-1:0] w_masked;
  int                   w_pos;
  int                   w_pick_int;

  assign w_dbl = {i_req, i_req};

  // Window covers positions last+1 .. last+NUM_REQ, i.e. one full lap after last.
  generate
    for (genvar i = 0; i < 2*NUM_REQ; i++) begin : g_mask
      assign w_win[i] = (i > int'(i_last)) && (i <= int'(i_last) + NUM_REQ);
    end
  endgenerate

  assign w_masked = w_dbl & w_win;

  always_comb begin
    w_pos = 0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_pos = i;
      end
    end
  end

  always_comb begin
    w_pick_int = (w_pos >= NUM_REQ) ? (w_pos - NUM_REQ) : w_pos;
  end

  assign o_pick    = IDX_W'(w_pick_int);
  assign o_any_req = |i_req;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin, burst-limited sharing of one FIFO write port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDX_W  = arb_idx_w(NUM_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0]  c_LAST_REQ  = IDX_W'(NUM_REQ - 1);
  localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_grant_id;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [IDX_W-1:0]    w_pick;
  logic                w_any_req;
  logic                w_grant_valid;
  logic                w_xfer;
  logic                w_last_beat;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req     (req_valid),
    .i_last    (r_last_grant),
    .o_pick    (w_pick),
    .o_any_req (w_any_req)
  );

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign w_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // fifo_full reaches grant state only through the transfer qualifier.
  assign w_grant_valid = req_valid[r_grant_id];
  assign w_xfer        = (r_state == GRANT) && w_grant_valid && !fifo_full;
  assign w_last_beat   = (r_beat_cnt == c_LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!w_grant_valid || (w_xfer && w_last_beat)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    if (r_state == GRANT) begin
      busy                  = 1'b1;
      req_ready[r_grant_id] = !fifo_full;
      fifo_wr_en            = w_grant_valid && !fifo_full;
      fifo_din              = w_slice[r_grant_id];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_grant <= c_LAST_REQ;
      r_grant_id   <= '0;
      r_beat_cnt   <= '0;
    end else if ((r_state == IDLE) && w_any_req) begin
      r_last_grant <= w_pick;
      r_grant_id   <= w_pick;
      r_beat_cnt   <= '0;
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign grant_id = r_grant_id;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter : directed self-checking bench for fifo_wr_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  req_valid1;
  logic [31:0] req_data1;
  logic [3:0]  req_ready1;
  logic        fifo_full1;
  logic        fifo_wr_en1;
  logic [7:0]  fifo_din1;
  logic [1:0]  grant_id1;
  logic        busy1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid1),
    .req_data   (req_data1),
    .req_ready  (req_ready1),
    .fifo_full  (fifo_full1),
    .fifo_wr_en (fifo_wr_en1),
    .fifo_din   (fifo_din1),
    .grant_id   (grant_id1),
    .busy       (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic f);
    @(negedge clk);
    req_valid = v;
    fifo_full = f;
    #1;
  endtask

  initial begin
    int nwr;
    int g;
    int seq [3];
    seq = '{0, 2, 0};

    rst        = 1'b0;
    req_valid  = '0;
    req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    fifo_full  = 1'b0;
    req_valid1 = '0;
    req_data1  = {8'h43, 8'h42, 8'h41, 8'h40};
    fifo_full1 = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_ready", req_ready, 0);
    check("rst_din", fifo_din, 0);
    check("rst_gid", grant_id, 0);
    @(negedge clk);
    rst = 1'b1;

    // All four requesting from reset: grants 0,1,2,3,0 with a one-cycle gap
    nwr = 0;
    for (int k = 0; k < 22; k++) begin
      cyc(4'b1111, 1'b0);
      if (k % 5 == 0) begin
        check("rr_idle_busy", busy, 0);
        check("rr_idle_wr", fifo_wr_en, 0);
      end else begin
        g = (k / 5) % 4;
        check("rr_gid", grant_id, g);
        check("rr_wr", fifo_wr_en, 1);
        check("rr_din", fifo_din, 8'h10 + g);
        check("rr_ready", req_ready, 1 << g);
      end
      if (k < 20 && fifo_wr_en) nwr++;
    end
    check("rr_writes_20", nwr, 16);
    cyc(4'b0000, 1'b0);
    check("rel_busy", busy, 1);
    check("rel_wr", fifo_wr_en, 0);

    // Full stall on grant 2 after two beats
    cyc(4'b0100, 1'b0);
    check("st_idle", busy, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(4'b0100, 1'b0);
      check("st_pre_gid", grant_id, 2);
      check("st_pre_wr", fifo_wr_en, 1);
    end
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0100, 1'b1);
      check("st_wr", fifo_wr_en, 0);
      check("st_ready", req_ready, 0);
      check("st_gid", grant_id, 2);
      check("st_busy", busy, 1);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(4'b0100, 1'b0);
      check("st_post_wr", fifo_wr_en, 1);
      check("st_post_ready", req_ready, 4'b0100);
    end
    cyc(4'b0000, 1'b0);
    check("st_end_busy", busy, 0);

    // Early release by requester 1
    req_data[15:8] = 8'hA1;
    cyc(4'b0010, 1'b0);
    check("er_idle", busy, 0);
    cyc(4'b0010, 1'b0);
    check("er_gid", grant_id, 1);
    check("er_wr1", fifo_wr_en, 1);
    check("er_din1", fifo_din, 8'hA1);
    req_data[15:8] = 8'hA2;
    cyc(4'b0010, 1'b0);
    check("er_wr2", fifo_wr_en, 1);
    check("er_din2", fifo_din, 8'hA2);
    cyc(4'b0000, 1'b0);
    check("er_drop_busy", busy, 1);
    check("er_drop_wr", fifo_wr_en, 0);
    cyc(4'b0000, 1'b0);
    check("er_back_idle", busy, 0);

    // Park last_grant on 3, then wrap with 4'b0101
    cyc(4'b1000, 1'b0);
    cyc(4'b1000, 1'b0);
    check("wr_gid3", grant_id, 3);
    cyc(4'b0000, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(4'b0101, 1'b0);
      check("wrap_ready13", req_ready & 4'b1010, 0);
      if (k % 5 == 0) begin
        check("wrap_idle", busy, 0);
      end else begin
        check("wrap_gid", grant_id, seq[k / 5]);
        check("wrap_wr", fifo_wr_en, 1);
      end
    end

    // Asynchronous reset mid-burst
    #2;
    rst = 1'b0;
    #1;
    check("ar_wr", fifo_wr_en, 0);
    check("ar_ready", req_ready, 0);
    check("ar_busy", busy, 0);
    check("ar_din", fifo_din, 0);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("ar_idle", busy, 0);
    cyc(4'b1111, 1'b0);
    check("ar_gid0", grant_id, 0);
    check("ar_busy1", busy, 1);

    // MAX_BURST=1: write, idle, write, idle with grants 0,1,2,3
    @(negedge clk);
    req_valid  = '0;
    req_valid1 = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      if (k % 2 == 0) begin
        check("mb1_idle_busy", busy1, 0);
        check("mb1_idle_wr", fifo_wr_en1, 0);
      end else begin
        g = (k / 2) % 4;
        check("mb1_gid", grant_id1, g);
        check("mb1_wr", fifo_wr_en1, 1);
        check("mb1_din", fifo_din1, 8'h40 + g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
